// File: rtl/seg7_pkg.sv
// Shared widths, 7-segment glyphs and BCD helpers.
// Glyphs are active-low, bit 0 = seg a .. bit 6 = seg g.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int BCD_W = 4;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Non-decimal nibbles collapse to 0 so digits stay in 0..9.
  function automatic logic [BCD_W-1:0] bcd_sat(
    input logic [BCD_W-1:0] n
  );
    return (n > BCD_MAX) ? '0 : n;
  endfunction

endpackage

// File: rtl/bcd_counter_display_if.sv
// Control/status bundle of the BCD counter display.
// master: enable, up, load, load_value out; digits, hex, tick, wrap in.
interface bcd_counter_display_if #(
  parameter int NUM_DIGITS = 2
);
  import seg7_pkg::*;

  logic                        enable;
  logic                        up;
  logic                        load;
  logic [BCD_W*NUM_DIGITS-1:0] load_value;
  logic [BCD_W*NUM_DIGITS-1:0] digits;
  logic [SEG_W*NUM_DIGITS-1:0] hex;
  logic                        tick;
  logic                        wrap;

  modport master (
    output enable,
    output up,
    output load,
    output load_value,
    input  digits,
    input  hex,
    input  tick,
    input  wrap
  );

  modport slave (
    input  enable,
    input  up,
    input  load,
    input  load_value,
    output digits,
    output hex,
    output tick,
    output wrap
  );

endinterface

// File: rtl/seg7_decoder.sv
// One-digit hex to active-low 7-segment decoder.
// bcd: 4-bit code in; seg: active-low segments out (bit 0 = a).
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_counter_display.sv
// Prescaled multi-digit up/down BCD counter with 7-seg outputs.
// Ports: CLOCK_50, reset (async, active-low), bus (slave modport).
module bcd_counter_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int TICK_COUNT = 50000000,
  parameter int PRESCALE_W =
    (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  bcd_counter_display_if.slave  bus
);

  localparam logic [PRESCALE_W-1:0] PRE_MAX =
    PRESCALE_W'(TICK_COUNT - 1);

  logic [PRESCALE_W-1:0]           pre_q;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] dig_q;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] dig_nx;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] dig_ld;
  logic [SEG_W*NUM_DIGITS-1:0]     hex_w;
  logic                            tick_q;
  logic                            wrap_q;
  logic                            step;
  logic                            carry;
  logic                            roll;

  assign step = bus.enable & ~bus.load
              & (pre_q == PRE_MAX);

  // Ripple carry/borrow; carry out of the top
  // digit means the whole range wrapped.
  always_comb begin
    dig_nx = dig_q;
    carry  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (bus.up) begin
          if (dig_q[i] == BCD_MAX) begin
            dig_nx[i] = '0;
          end else begin
            dig_nx[i] = dig_q[i] + 4'd1;
            carry     = 1'b0;
          end
        end else begin
          if (dig_q[i] == '0) begin
            dig_nx[i] = BCD_MAX;
          end else begin
            dig_nx[i] = dig_q[i] - 4'd1;
            carry     = 1'b0;
          end
        end
      end
    end
    roll = carry;
  end

  always_comb begin
    dig_ld = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_ld[i] =
        bcd_sat(bus.load_value[BCD_W*i +: BCD_W]);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      pre_q  <= '0;
      dig_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= step;
      wrap_q <= step & roll;
      if (bus.load) begin
        pre_q <= '0;
        dig_q <= dig_ld;
      end else if (bus.enable) begin
        if (step) begin
          pre_q <= '0;
          dig_q <= dig_nx;
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decoder u_dec (
      .bcd (dig_q[g]),
      .seg (hex_w[SEG_W*g +: SEG_W])
    );
  end

  assign bus.digits = dig_q;
  assign bus.hex    = hex_w;
  assign bus.tick   = tick_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Scoreboard bench for bcd_counter_display.
// Two digits, four cycles per step.
module tb_bcd_counter_display;

  localparam int ND = 2;
  localparam int TC = 4;

  typedef struct {
    logic [7:0]  dig;
    logic [13:0] hex;
    logic        wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bcd_counter_display_if #(.NUM_DIGITS(ND)) bus();

  bcd_counter_display #(
    .NUM_DIGITS (ND),
    .TICK_COUNT (TC)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (bus.slave)
  );

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000
  };

  function automatic logic [13:0] hex_of(int v);
    return {seg_tab[v / 10], seg_tab[v % 10]};
  endfunction

  function automatic logic [7:0] bcd_of(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic push(int v, bit w);
    exp_t e;
    e.dig  = bcd_of(v);
    e.hex  = hex_of(v);
    e.wrap = w;
    sb.push_back(e);
  endtask

  task automatic check(
    string name, logic [31:0] act, logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               name, act, exp);
    end
  endtask

  // Counts negedges until tick, bounded.
  task automatic wait_step(int want);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.tick) seen = 1'b1;
    end
    if (!seen) n = 99;
    check("step_latency", n, want);
  endtask

  task automatic do_load(logic [7:0] v);
    bus.load = 1'b1;
    bus.load_value = v;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.tick) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick digits %0h",
                 bus.digits);
      end else begin
        mon_e = sb.pop_front();
        check("sb_digits", bus.digits, mon_e.dig);
        check("sb_hex", bus.hex, mon_e.hex);
        check("sb_wrap", bus.wrap, mon_e.wrap);
      end
    end else if (bus.wrap) begin
      checks++;
      errors++;
      $display("FAIL wrap_without_tick got 1 want 0");
    end
  end

  initial begin
    int quiet;
    bus.enable = 1'b1;
    bus.up = 1'b1;
    bus.load = 1'b0;
    bus.load_value = '0;

    #12;
    check("rst_digits", bus.digits, 8'h00);
    check("rst_hex", bus.hex, 14'b1000000_1000000);
    check("rst_tick", bus.tick, 1'b0);
    check("rst_wrap", bus.wrap, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    push(1, 1'b0);
    wait_step(4);
    push(2, 1'b0);
    wait_step(4);

    do_load(8'h98);
    check("load98", bus.digits, 8'h98);
    check("load98_tick", bus.tick, 1'b0);
    push(99, 1'b0);
    wait_step(4);
    push(0, 1'b1);
    wait_step(4);
    check("hex0_at_00", bus.hex[6:0], 7'b1000000);

    bus.up = 1'b0;
    do_load(8'h10);
    check("load10", bus.digits, 8'h10);
    check("load10_hex", bus.hex, 14'b1111001_1000000);
    push(9, 1'b0);
    wait_step(4);
    push(8, 1'b0);
    wait_step(4);
    for (int v = 7; v >= 0; v--) begin
      push(v, 1'b0);
      wait_step(4);
    end
    push(99, 1'b1);
    wait_step(4);

    repeat (2) @(negedge clk);
    bus.enable = 1'b0;
    bus.up = 1'b1;
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.tick || bus.wrap) quiet++;
    end
    check("hold_digits", bus.digits, 8'h99);
    check("hold_pulses", quiet, 0);
    bus.enable = 1'b1;
    push(0, 1'b1);
    wait_step(2);

    repeat (3) @(negedge clk);
    do_load(8'hF7);
    check("loadF7", bus.digits, 8'h07);
    check("loadF7_tick", bus.tick, 1'b0);
    check("loadF7_wrap", bus.wrap, 1'b0);
    push(8, 1'b0);
    wait_step(4);

    do_load(8'h45);
    check("load45", bus.digits, 8'h45);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_digits", bus.digits, 8'h00);
    check("async_hex", bus.hex, 14'b1000000_1000000);
    check("async_tick", bus.tick, 1'b0);
    check("async_wrap", bus.wrap, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    push(1, 1'b0);
    wait_step(4);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
